// File: rtl/router_pkg.sv
// Shared router definitions: byte format, header field positions and limits.
package router_pkg;

    localparam int BYTE_W      = 8;
    localparam int ADDR_LSB    = 0;
    localparam int ADDR_MSB    = 1;
    localparam int LEN_LSB     = 2;
    localparam int LEN_MSB     = 7;
    localparam int MAX_PAYLOAD = 63;
    localparam int PKT_CNT_W   = 7;

    // A header announces its payload length; the parity byte adds one more read.
    function automatic logic [PKT_CNT_W-1:0] pkt_len_load(input logic [BYTE_W-1:0] hdr);
        return {1'b0, hdr[LEN_MSB:LEN_LSB]} + 7'd1;
    endfunction

endpackage

// File: rtl/router_fifo_if.sv
// Write/read handshake bundle between the register stage, one output FIFO and its client.
// Status ports (ROUTER_FIFO_STATUS_EN) are plain ports on router_fifo, not part of this bundle.
interface router_fifo_if
    import router_pkg::*;
#(
    parameter int WIDTH = BYTE_W
);
    logic             write_enb;
    logic             read_enb;
    logic             lfd_state;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic             empty;
    logic             full;
    logic             pkt_done;

    modport master (
        output write_enb, read_enb, lfd_state, data_in,
        input  data_out, empty, full, pkt_done
    );

    modport slave (
        input  write_enb, read_enb, lfd_state, data_in,
        output data_out, empty, full, pkt_done
    );
endinterface

// File: rtl/router_fifo_mem.sv
// Storage array for router_fifo: synchronous write, asynchronous read.
module router_fifo_mem #(
    parameter int DEPTH = 16,
    parameter int DW    = 9,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);
    logic [DW-1:0] mem_reg [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_reg[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_reg[rd_addr];
endmodule

// File: rtl/router_fifo.sv
// Per-port router output FIFO with header-tagged entries and read-side packet tracking.
// Optional ROUTER_FIFO_STATUS_EN adds occupancy count and sticky overflow outputs.
module router_fifo
    import router_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = BYTE_W,
    localparam int AW   = $clog2(DEPTH),
    localparam int PW   = AW + 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          soft_reset,
    router_fifo_if.slave  bus
`ifdef ROUTER_FIFO_STATUS_EN
    ,
    output logic [PW-1:0] count,
    output logic          overflow
`endif
);
    logic [PW-1:0]        wr_ptr_reg, rd_ptr_reg;
    logic [PKT_CNT_W-1:0] pkt_cnt_reg, pkt_cnt_next;
    logic [WIDTH-1:0]     data_out_reg, data_out_next;
    logic                 pkt_done_reg, pkt_done_next;
    logic                 empty_w, full_w, wr_acc, rd_acc;
    logic [WIDTH:0]       rd_entry;
    logic                 rd_tag;
    logic [WIDTH-1:0]     rd_byte;

    assign empty_w = (wr_ptr_reg == rd_ptr_reg);
    assign full_w  = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) &&
                     (wr_ptr_reg[AW] != rd_ptr_reg[AW]);
    assign wr_acc  = bus.write_enb && !full_w;
    assign rd_acc  = bus.read_enb && !empty_w;

    router_fifo_mem #(
        .DEPTH (DEPTH),
        .DW    (WIDTH + 1)
    ) u_mem (
        .clock   (clock),
        .wr_en   (wr_acc && !soft_reset),
        .wr_addr (wr_ptr_reg[AW-1:0]),
        .wr_data ({bus.lfd_state, bus.data_in}),
        .rd_addr (rd_ptr_reg[AW-1:0]),
        .rd_data (rd_entry)
    );

    assign rd_tag  = rd_entry[WIDTH];
    assign rd_byte = rd_entry[WIDTH-1:0];

    always_comb begin
        pkt_cnt_next  = pkt_cnt_reg;
        pkt_done_next = 1'b0;
        data_out_next = data_out_reg;
        if (rd_acc) begin
            data_out_next = rd_byte;
            if (rd_tag) begin
                pkt_cnt_next = pkt_len_load(rd_byte);
            end else if (pkt_cnt_reg != '0) begin
                pkt_cnt_next  = pkt_cnt_reg - 1'b1;
                pkt_done_next = (pkt_cnt_reg == 7'd1);
            end
        end else if (pkt_done_reg) begin
            // Bus idles to zero once the parity byte has been consumed.
            data_out_next = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            pkt_cnt_reg  <= '0;
            data_out_reg <= '0;
            pkt_done_reg <= 1'b0;
        end else if (soft_reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            pkt_cnt_reg  <= '0;
            data_out_reg <= '0;
            pkt_done_reg <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (rd_acc) rd_ptr_reg <= rd_ptr_reg + 1'b1;
            pkt_cnt_reg  <= pkt_cnt_next;
            data_out_reg <= data_out_next;
            pkt_done_reg <= pkt_done_next;
        end
    end

    assign bus.data_out = data_out_reg;
    assign bus.pkt_done = pkt_done_reg;
    assign bus.empty    = empty_w;
    assign bus.full     = full_w;

`ifdef ROUTER_FIFO_STATUS_EN
    logic overflow_reg;

    assign count    = wr_ptr_reg - rd_ptr_reg;
    assign overflow = overflow_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overflow_reg <= 1'b0;
        end else if (soft_reset) begin
            overflow_reg <= 1'b0;
        end else if (bus.write_enb && full_w && !rd_acc) begin
            overflow_reg <= 1'b1;
        end
    end
`endif
endmodule

// File: doc/router_fifo.md
# router_fifo

Per-port output FIFO of the 1x3 router. Sits directly downstream of the register stage: it stores each byte the register stage drives, tagged with the header-load flag so the first byte of every packet is known on the read side. On the read side it tracks the packet's length from the stored header, so the destination client's read stream and packet boundaries are well defined. One instance exists per output port, three in total.

## Interface
- DEPTH, 16: number of entries; power of two, minimum 4.
- WIDTH, 8: data byte width; fixed by the router byte format.
- clock  input  1  rising-edge system clock.
- reset  input  1  asynchronous, active-high reset.
- soft_reset  input  1  synchronous flush, asserted by the sync block on read timeout.
- write_enb  input  1  write request for this port.
- read_enb  input  1  read request from the destination client.
- lfd_state  input  1  marks the current write byte as a packet header.
- data_in  input  WIDTH  byte from the register stage.
- data_out  output  WIDTH  registered read data.
- empty  output  1  no stored entries.
- full  output  1  DEPTH entries stored.
- pkt_done  output  1  one-cycle pulse, aligned with data_out, when the last byte of a packet (the parity byte) is presented.

## Operation
- Storage: DEPTH entries of WIDTH+1 bits. Bit WIDTH holds the lfd_state value captured with the byte.
- Pointers: read and write pointers of log2(DEPTH)+1 bits.
  - empty when the pointers are equal.
  - full when the low bits are equal and the MSBs differ.
  - Pointers wrap naturally at 2·DEPTH.
- Write acceptance: a write is accepted when write_enb is high and full is low.
  - The byte and lfd_state are stored and the write pointer increments.
  - A write while full is dropped and no state changes.
- Read acceptance: a read is accepted when read_enb is high and empty is low.
  - The entry is registered to data_out and the read pointer increments.
  - A read while empty has no effect, and data_out holds its value.
- Simultaneous read and write: both are judged on the pre-edge flags.
  - When full, only the read proceeds.
  - When empty, only the write proceeds.
  - Otherwise both proceed and occupancy is unchanged.
- Packet counter: 7 bits, read side.
  - On reading an entry with the tag bit set, it loads data[7:2]+1 (payload plus parity).
  - On reading an untagged entry with a nonzero counter, it decrements.
  - When an untagged read takes the counter from 1 to 0, pkt_done pulses with that byte.
- Idle output: on the cycle after pkt_done, if no read is accepted, data_out returns to 0.
- Soft reset: soft_reset high at a clock edge has priority over read and write in that cycle. It clears:
  - both pointers;
  - the packet counter;
  - data_out and pkt_done.
  - Memory contents are don't-care.

## Timing
- Reset values: data_out=0, pkt_done=0, empty=1, full=0, both pointers 0, packet counter 0.
- reset takes effect asynchronously, including in mid-packet. A partially read packet is discarded.
- Read latency: data_out and pkt_done update at the edge that accepts the read (one cycle after read_enb is sampled).
- Flag timing: empty and full are decoded combinationally from the registered pointers, so they change only after clock edges.
- Write-to-read latency: a byte written at edge N can be read at edge N+1. empty deasserts after edge N.

## Configuration
- ROUTER_FIFO_STATUS_EN
  - Defined: adds outputs count (log2(DEPTH)+1 bits, current occupancy, reset 0) and overflow (1 bit, sticky, set when write_enb is high while full is high and no read is accepted that cycle).
  - Both new outputs clear on reset or soft_reset.
  - Undefined: neither port exists. Behaviour is otherwise identical.

## Structure
- Shared package router_pkg holds:
  - the byte width constant;
  - header field positions (address [1:0], payload length [7:2]);
  - the maximum payload length constant (63).
- Sub-module router_fifo_mem: a plain synchronous-write, asynchronous-read register array of DEPTH x (WIDTH+1). Pointer, counter and flag logic stay in router_fifo.

## Test plan
- Reset and empty read: reset pulse, then read_enb=1 for 3 cycles -> empty=1, data_out=0, pointers stay 0.
- Normal packet: write header 0x0D (payload length 3) with lfd_state=1, then 0x11, 0x22, 0x33 and parity 0x0F, then read 5 bytes -> data_out sequence 0x0D, 0x11, 0x22, 0x33, 0x0F; pkt_done high only with 0x0F; data_out=0 the following idle cycle.
- Full and overflow: write 17 bytes with no reads -> full=1 after 16; the 17th byte is dropped; reads return bytes 1..16 in order. With ROUTER_FIFO_STATUS_EN: count=16, overflow=1.
- Simultaneous at full: with full=1, read_enb=1 and write_enb=1 in one cycle -> only the read occurs; full drops; the next write succeeds.
- Wrap-around: 40 interleaved writes/reads keeping occupancy at 1–3 -> data order preserved across pointer wrap; flags correct throughout.
- Soft reset mid-packet: after reading the header plus 1 of 3 payload bytes, assert soft_reset -> empty=1, data_out=0, counter 0. A following packet (header 0x05) reads correctly, with pkt_done on its 2nd byte after the header.
